uart_num_parser: RTL and testbench

- Converts the received UART byte stream into signed decimal integers for the solver core.
- Sits directly downstream of the UART receive path. Consumes the byte-received pulse and the receive shift register.
- Emits one value strobe per ASCII number, plus end-of-line and end-of-input events and running counts.
- Has no backpressure: the byte rate is at least 16 clocks per byte, far below the parse rate.

---
 rtl/uart_num_parser.sv | 159 +++++++++++++++
 tb/tb_uart_num_parser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_num_parser.sv
// ASCII byte stream to decimal integer parser for the solver front end.
// Define PARSER_SIGNED_EN to accept a leading '-' and signed saturation.
module uart_num_parser #(
  parameter int VAL_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx_char_received,
  input  logic [31:0]      rx_out,
  output logic             num_valid,
  output logic [VAL_W-1:0] num_value,
  output logic             num_ovf,
  output logic             eol,
  output logic             done,
  output logic [CNT_W-1:0] num_count,
  output logic [CNT_W-1:0] line_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NEG  = 2'd1;
  localparam logic [1:0] NUM  = 2'd2;

  localparam int PW = VAL_W + 4;
`ifdef PARSER_SIGNED_EN
  localparam logic [PW-1:0] MAX =
    {{5{1'b0}}, {(VAL_W-1){1'b1}}};
`else
  localparam logic [PW-1:0] MAX =
    {{4{1'b0}}, {VAL_W{1'b1}}};
`endif
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic             rcv_q;
  logic [1:0]       state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic             nv_q, nv_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic             novf_q, novf_d;
  logic             eol_q, eol_d;
  logic [CNT_W-1:0] ncnt_q, ncnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;

  logic [7:0]       b;
  logic [3:0]       dig;
  logic             is_dig, is_cr, is_nl, is_eot;
  logic             is_min;
  logic [PW-1:0]    acc_x, prod;
  logic [VAL_W-1:0] emit_val;
  logic             emit;
  logic             unused_bits;

  assign b           = rx_out[7:0];
  assign unused_bits = ^rx_out[31:8];
  assign dig         = 4'(b - 8'h30);
  assign is_dig      = (b >= 8'h30) && (b <= 8'h39);
  assign is_cr       = (b == 8'h0d);
  assign is_nl       = (b == 8'h0a);
  assign is_eot      = (b == 8'h04);
`ifdef PARSER_SIGNED_EN
  assign is_min      = (b == 8'h2d);
`else
  assign is_min      = 1'b0;
`endif

  // Wide enough that acc*10+9 never wraps before the MAX test.
  assign acc_x = {4'b0, acc_q};
  assign prod  = (acc_x << 3) + (acc_x << 1)
               + {{(PW-4){1'b0}}, dig};

  assign emit_val = neg_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    done_d  = done_q;
    emit    = 1'b0;
    eol_d   = 1'b0;
    if (rcv_q && !done_q) begin
      unique case (1'b1)
        is_dig: begin
          if (state_q != NUM) begin
            acc_d   = {{(VAL_W-4){1'b0}}, dig};
            ovf_d   = 1'b0;
            neg_d   = (state_q == NEG);
            state_d = NUM;
          end else if (ovf_q || prod > MAX) begin
            acc_d = MAX[VAL_W-1:0];
            ovf_d = 1'b1;
          end else begin
            acc_d = prod[VAL_W-1:0];
          end
        end
        is_min: begin
          emit    = (state_q == NUM);
          state_d = NEG;
        end
        is_cr: begin
        end
        default: begin
          emit    = (state_q == NUM);
          state_d = IDLE;
          eol_d   = is_nl;
          done_d  = is_eot;
        end
      endcase
    end
    nv_d   = emit;
    val_d  = emit ? emit_val : val_q;
    novf_d = emit ? ovf_q : novf_q;
    ncnt_d = emit ? ncnt_q + CNT_ONE : ncnt_q;
    lcnt_d = eol_d ? lcnt_q + CNT_ONE : lcnt_q;
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      rcv_q   <= 1'b0;
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      nv_q    <= 1'b0;
      val_q   <= '0;
      novf_q  <= 1'b0;
      eol_q   <= 1'b0;
      ncnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      rcv_q   <= rx_char_received;
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      nv_q    <= nv_d;
      val_q   <= val_d;
      novf_q  <= novf_d;
      eol_q   <= eol_d;
      ncnt_q  <= ncnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign num_valid  = nv_q;
  assign num_value  = val_q;
  assign num_ovf    = novf_q;
  assign eol        = eol_q;
  assign done       = done_q;
  assign num_count  = ncnt_q;
  assign line_count = lcnt_q;

endmodule

// File: tb/tb_uart_num_parser.sv
// Scoreboard bench for uart_num_parser; a behavioural model
// queues expected numbers and line ends as bytes are driven.
module tb_uart_num_parser;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        rx_char_received;
  logic [31:0] rx_out;
  logic        num_valid;
  logic [31:0] num_value;
  logic        num_ovf;
  logic        eol;
  logic        done;
  logic [15:0] num_count;
  logic [15:0] line_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint v;
    bit     o;
    longint c;
  } num_t;

  typedef struct {
    longint c;
    bit     with_num;
  } eol_t;

  num_t nq[$];
  eol_t eq[$];

`ifdef PARSER_SIGNED_EN
  localparam longint MAXV = 64'd2147483647;
`else
  localparam longint MAXV = 64'd4294967295;
`endif

  int     m_st;
  longint m_acc;
  bit     m_ovf, m_neg, m_done;
  longint m_ncnt, m_lcnt;

  uart_num_parser #(.VAL_W(32), .CNT_W(16)) dut (
    .clk_100MHz       (clk_100MHz),
    .reset            (reset),
    .rx_char_received (rx_char_received),
    .rx_out           (rx_out),
    .num_valid        (num_valid),
    .num_value        (num_value),
    .num_ovf          (num_ovf),
    .eol              (eol),
    .done             (done),
    .num_count        (num_count),
    .line_count       (line_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic longint dut_val();
`ifdef PARSER_SIGNED_EN
    return longint'($signed(num_value));
`else
    return longint'(num_value);
`endif
  endfunction

  task automatic m_reset();
    m_st = 0; m_acc = 0; m_ovf = 0;
    m_neg = 0; m_done = 0;
    m_ncnt = 0; m_lcnt = 0;
  endtask

  task automatic m_emit();
    num_t e;
    m_ncnt = (m_ncnt + 1) % 65536;
    e.v = m_neg ? -m_acc : m_acc;
    e.o = m_ovf;
    e.c = m_ncnt;
    nq.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] c);
    bit   was_num;
    eol_t e;
    if (m_done) return;
    was_num = (m_st == 2);
    if (c >= 8'h30 && c <= 8'h39) begin
      if (!was_num) begin
        m_neg = (m_st == 1);
        m_acc = longint'(c - 8'h30);
        m_ovf = 0;
        m_st  = 2;
      end else begin
        m_acc = m_acc * 10 + longint'(c - 8'h30);
        if (m_acc > MAXV) begin
          m_acc = MAXV;
          m_ovf = 1;
        end
      end
    end else if (c == 8'h0d) begin
    end
`ifdef PARSER_SIGNED_EN
    else if (c == 8'h2d) begin
      if (was_num) m_emit();
      m_st = 1;
    end
`endif
    else begin
      if (was_num) m_emit();
      m_st = 0;
      if (c == 8'h0a) begin
        m_lcnt = (m_lcnt + 1) % 65536;
        e.c = m_lcnt;
        e.with_num = was_num;
        eq.push_back(e);
      end
      if (c == 8'h04) m_done = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] c);
    model_byte(c);
    rx_char_received = 1'b1;
    rx_out = {24'h0, c};
    @(negedge clk_100MHz);
    rx_char_received = 1'b0;
    repeat (3) @(negedge clk_100MHz);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i]);
  endtask

  always @(negedge clk_100MHz) begin
    if (reset && num_valid) begin
      if (nq.size() == 0)
        chk("num_unexpected", 1, 0);
      else begin
        num_t e;
        e = nq.pop_front();
        chk("num_value", dut_val(), e.v);
        chk("num_ovf", num_ovf, e.o);
        chk("num_count", num_count, e.c);
      end
    end
    if (reset && eol) begin
      if (eq.size() == 0)
        chk("eol_unexpected", 1, 0);
      else begin
        eol_t e;
        e = eq.pop_front();
        chk("line_count", line_count, e.c);
        chk("eol_with_num", num_valid, e.with_num);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nv"}, num_valid, 0);
    chk({tag, "_val"}, num_value, 0);
    chk({tag, "_ovf"}, num_ovf, 0);
    chk({tag, "_eol"}, eol, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ncnt"}, num_count, 0);
    chk({tag, "_lcnt"}, line_count, 0);
  endtask

  initial begin
    rx_char_received = 1'b0;
    rx_out = '0;
    reset = 1'b0;
    m_reset();
    repeat (3) @(negedge clk_100MHz);
    chk_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk_100MHz);

    send_str("12,345\n");
    chk("cnt_a", num_count, 2);
    chk("lines_a", line_count, 1);
    send_str("-17 3-4\n");
    send_str("007 -0\n");
    send_str("2147483648\n");
    send_str("5\n");
    send_str("99999999999\n");
    send_str("1\r\n\n-\n");

    send_str("98");
    @(negedge clk_100MHz);
    reset = 1'b0;
    m_reset();
    #1;
    chk_reset_vals("mid");
    @(negedge clk_100MHz);
    reset = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    send_str("7\n");
    chk("cnt_after_rst", num_count, 1);

    send_str("42");
    model_byte(8'h04);
    rx_char_received = 1'b1;
    rx_out = 32'h04;
    @(negedge clk_100MHz);
    rx_char_received = 1'b0;
    chk("done_n1", done, 0);
    @(negedge clk_100MHz);
    chk("done_n2", done, 1);
    chk("eot_flush", num_valid, 1);
    repeat (2) @(negedge clk_100MHz);
    send_str("9\n");
    chk("done_held", done, 1);

    repeat (8) @(negedge clk_100MHz);
    chk("num_q_left", nq.size(), 0);
    chk("eol_q_left", eq.size(), 0);
    chk("final_ncnt", num_count, m_ncnt);
    chk("final_lcnt", line_count, m_lcnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
